// File: rtl/down_count_monitor.sv
// -----------------------------------------------------------------------------
// down_count_monitor
//
// Purpose:
//   Qualifies the q bus of a ripple (asynchronous T-flip-flop) down counter.
//   The bus is brought into the clk domain through a two-flop synchronizer.
//   It is then filtered so that a value is accepted only after STABLE_CYCLES
//   further consecutive equal samples. Each accepted step is checked: a legal
//   decrement, the 0 -> max wrap, or an illegal jump.
//
// Parameters:
//   WIDTH          width of the monitored count bus
//   STABLE_CYCLES  equal synchronized samples needed before acceptance (1..7)
//   WRAP_W         width of the saturating wrap event counter
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   cnt_in           raw counter q bus, asynchronous to clk
//   err_clr          clears step_err_sticky (a new error on the same edge wins)
//   cnt_stable       last accepted count
//   new_val          one-cycle pulse when cnt_stable takes a new value
//   wrap_pulse       one-cycle pulse on an accepted 0 -> 2^WIDTH-1 step
//   wrap_count       saturating number of wraps since reset
//   step_err         one-cycle pulse on an accepted illegal step
//   step_err_sticky  latched step error
// -----------------------------------------------------------------------------
module down_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  cnt_stable,
    output logic              new_val,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err,
    output logic              step_err_sticky
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_INIT  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam logic [2:0]        RUN_MAX  = 3'(STABLE_CYCLES);
    localparam logic [2:0]        RUN_ONE  = 3'd1;
    localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    // A legal step is exactly one below the held value.
    // From zero, the only legal step is the wrap, which is handled separately.
    function automatic logic is_decrement(input logic [WIDTH-1:0] old_v,
                                          input logic [WIDTH-1:0] new_v);
        return (old_v != CNT_ZERO) && (new_v == (old_v - CNT_ONE));
    endfunction

    state_t            state_q, state_d;
    logic              fill_q, fill_d;
    logic              primed_q, primed_d;
    logic [WIDTH-1:0]  s1_q, s1_d;
    logic [WIDTH-1:0]  s2_q, s2_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [2:0]        run_q, run_d;
    logic [WIDTH-1:0]  cnt_stable_q, cnt_stable_d;
    logic              new_val_q, new_val_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              step_err_q, step_err_d;
    logic              sticky_q, sticky_d;
    logic              accept_s;

    // Next-state logic: synchronizer, fill sequencing, glitch filter and step checker.
    always_comb begin
        s1_d         = cnt_in;
        s2_d         = s1_q;
        state_d      = state_q;
        fill_d       = fill_q;
        primed_d     = primed_q;
        cand_d       = cand_q;
        run_d        = run_q;
        cnt_stable_d = cnt_stable_q;
        new_val_d    = 1'b0;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        step_err_d   = 1'b0;
        accept_s     = 1'b0;

        if (err_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end

        // Filter runs once s2 holds real samples.
        // The first filter edge always reloads the candidate, so the
        // post-reset cand value of 0 is never mistaken for a sample.
        if (state_q != ST_FILL) begin
            if (!primed_q || (s2_q != cand_q)) begin
                cand_d   = s2_q;
                run_d    = 3'd0;
                primed_d = 1'b1;
            end else if (run_q < RUN_MAX) begin
                run_d    = run_q + RUN_ONE;
                accept_s = (run_q == (RUN_MAX - RUN_ONE));
            end else begin
                run_d = run_q;
            end
        end else begin
            run_d = run_q;
        end

        case (state_q)
            ST_FILL: begin
                // Two edges are needed after reset before s2 carries a real sample.
                if (fill_q) begin
                    fill_d  = 1'b0;
                    state_d = ST_INIT;
                end else begin
                    fill_d = 1'b1;
                end
            end
            ST_INIT: begin
                if (accept_s) begin
                    cnt_stable_d = cand_q;
                    new_val_d    = 1'b1;
                    state_d      = ST_TRACK;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_TRACK: begin
                if (accept_s && (cand_q != cnt_stable_q)) begin
                    cnt_stable_d = cand_q;
                    new_val_d    = 1'b1;
                    if ((cnt_stable_q == CNT_ZERO) && (cand_q == CNT_MAX)) begin
                        wrap_pulse_d = 1'b1;
                        if (wrap_count_q != WRAP_MAX) begin
                            wrap_count_d = wrap_count_q + WRAP_ONE;
                        end else begin
                            wrap_count_d = wrap_count_q;
                        end
                    end else if (is_decrement(cnt_stable_q, cand_q)) begin
                        wrap_pulse_d = 1'b0;
                    end else begin
                        step_err_d = 1'b1;
                        sticky_d   = 1'b1;
                    end
                end else begin
                    // An acceptance equal to the held value was only a glitch that returned.
                    cnt_stable_d = cnt_stable_q;
                end
            end
            default: begin
                state_d = ST_FILL;
                fill_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            fill_q       <= 1'b0;
            primed_q     <= 1'b0;
            s1_q         <= {WIDTH{1'b0}};
            s2_q         <= {WIDTH{1'b0}};
            cand_q       <= {WIDTH{1'b0}};
            run_q        <= 3'd0;
            cnt_stable_q <= {WIDTH{1'b0}};
            new_val_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= {WRAP_W{1'b0}};
            step_err_q   <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            primed_q     <= primed_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cand_q       <= cand_d;
            run_q        <= run_d;
            cnt_stable_q <= cnt_stable_d;
            new_val_q    <= new_val_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            step_err_q   <= step_err_d;
            sticky_q     <= sticky_d;
        end
    end

    assign cnt_stable      = cnt_stable_q;
    assign new_val         = new_val_q;
    assign wrap_pulse      = wrap_pulse_q;
    assign wrap_count      = wrap_count_q;
    assign step_err        = step_err_q;
    assign step_err_sticky = sticky_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_down_count_monitor
//
// Directed bench for down_count_monitor.
// The main instance (dut1) uses the default parameters.
// A second instance (dut2, WRAP_W=2) checks wrap counter saturation.
// Each value driven on cnt_in pushes its expected acceptance event onto a
// queue. The monitor pops that event when dut1 raises new_val.
// -----------------------------------------------------------------------------
module tb_down_count_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rst2;
    logic       err_clr;
    logic [3:0] cnt_in;

    logic [3:0] cs1, cs2;
    logic       nv1, nv2, wp1, wp2, se1, se2, st1, st2;
    logic [7:0] wc1;
    logic [1:0] wc2;

    down_count_monitor #(.WIDTH(4), .STABLE_CYCLES(2), .WRAP_W(8)) dut1 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .err_clr(err_clr),
        .cnt_stable(cs1), .new_val(nv1), .wrap_pulse(wp1), .wrap_count(wc1),
        .step_err(se1), .step_err_sticky(st1)
    );

    down_count_monitor #(.WIDTH(4), .STABLE_CYCLES(2), .WRAP_W(2)) dut2 (
        .clk(clk), .rst(rst2), .cnt_in(cnt_in), .err_clr(err_clr),
        .cnt_stable(cs2), .new_val(nv2), .wrap_pulse(wp2), .wrap_count(wc2),
        .step_err(se2), .step_err_sticky(st2)
    );

    typedef struct packed {
        logic [3:0] val;
        logic       wrap;
        logic       err;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         errors = 0;
    int         checks = 0;
    int         nv1_n  = 0;
    int         wp2_n  = 0;
    logic       mon_en = 1'b0;
    logic       have_last = 1'b0;
    logic [3:0] last_v = 4'd0;
    logic [7:0] exp_wc = 8'd0;
    logic       exp_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Push the event a held value should produce once dut1 accepts it.
    task automatic expect_val(input logic [3:0] v);
        ev_t e;
        e.val  = v;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (have_last && (v == last_v)) return;
        if (have_last) begin
            e.wrap = (last_v == 4'd0) && (v == 4'hF);
            e.err  = !e.wrap && (v != (last_v - 4'd1));
        end
        exp_q.push_back(e);
        have_last = 1'b1;
        last_v    = v;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        expect_val(v);
        cnt_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle reset of dut1, then walk the fill and INIT acceptance path.
    task automatic do_reset(input logic [3:0] v);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        cnt_in = v;
        rst    = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {14'd0, cs1, nv1, wp1, wc1, se1, st1}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk("fill_no_change", {27'd0, nv1, cs1}, 32'd0);
        end
        @(posedge clk); #1;
        chk("init_accept_val", 32'(cs1), 32'(v));
        chk("init_accept_flags", {24'd0, nv1, wp1, se1, st1, 4'd0}, {24'd0, 4'b1000, 4'd0});
        chk("init_wrap_count", 32'(wc1), 32'd0);
        @(posedge clk); #1;
        chk("init_pulse_width", 32'(nv1), 32'd0);
        have_last  = 1'b1;
        last_v     = v;
        exp_wc     = 8'd0;
        exp_sticky = 1'b0;
        mon_en     = 1'b1;
    endtask

    // Scoreboard monitor: compare each dut1 acceptance against the queue head.
    always @(negedge clk) begin
        if (nv1) nv1_n++;
        if (wp2) wp2_n++;
        if (mon_en) begin
            if (nv1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_new_val", {28'd0, cs1}, 32'hFFFF_FFFF);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.wrap && (exp_wc != 8'hFF)) exp_wc = exp_wc + 8'd1;
                    if (ev.err) exp_sticky = 1'b1;
                    chk("cnt_stable", 32'(cs1), 32'(ev.val));
                    chk("wrap_pulse", 32'(wp1), 32'(ev.wrap));
                    chk("step_err", 32'(se1), 32'(ev.err));
                    chk("wrap_count", 32'(wc1), 32'(exp_wc));
                    chk("sticky", 32'(st1), 32'(exp_sticky));
                end
            end else begin
                chk("no_stray_pulse", {30'd0, wp1, se1}, 32'd0);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        rst2    = 1'b1;
        err_clr = 1'b0;
        cnt_in  = 4'hA;

        // Reset with 4'hA held: fill holds, then INIT accepts at edge 5.
        do_reset(4'hA);
        hold(4'hA, 4);

        // Full down count from 15 through 0 and the wrap back to 15.
        nv1_n = 0;
        do_reset(4'hF);
        for (int v = 14; v >= 0; v--) hold(4'(v), 6);
        hold(4'hF, 6);
        chk("down_count_new_vals", 32'(nv1_n), 32'd17);
        chk("down_count_wraps", 32'(wc1), 32'd1);
        chk("down_count_sticky", 32'(st1), 32'd0);

        // One-cycle glitch to 0 between 8 and 7 must never be accepted.
        do_reset(4'd8);
        cnt_in = 4'd0;
        @(posedge clk); #1;
        hold(4'd7, 8);
        chk("glitch_result", 32'(cs1), 32'd7);

        // Illegal jump 7 -> 3, then clear, then 3 -> 9 with err_clr on the acceptance edge.
        hold(4'd3, 8);
        chk("sticky_set", 32'(st1), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr    = 1'b0;
        exp_sticky = 1'b0;
        chk("sticky_cleared", 32'(st1), 32'd0);
        expect_val(4'd9);
        cnt_in = 4'd9;
        repeat (4) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_vs_err_accept", 32'(nv1), 32'd1);
        chk("clr_vs_err_sticky", 32'(st1), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Five wraps on dut2 with a 2-bit saturating wrap counter.
        expect_val(4'hF);
        cnt_in = 4'hF;
        rst2   = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("dut2_init_val", 32'(cs2), 32'd15);
        wp2_n = 0;
        for (int w = 0; w < 5; w++) begin
            for (int v = 14; v >= 0; v--) hold(4'(v), 6);
            hold(4'hF, 6);
            chk("dut2_wrap_count", 32'(wc2), (w + 1 > 3) ? 32'd3 : 32'(w + 1));
        end
        chk("dut2_wrap_pulses", 32'(wp2_n), 32'd5);
        chk("dut2_no_err", 32'(st2), 32'd0);
        chk("dut1_wrap_count", 32'(wc1), 32'(exp_wc));

        // Build wrap_count=2 with sticky=1, then a one-cycle reset mid-TRACK.
        do_reset(4'd1);
        hold(4'd0, 6);
        hold(4'hF, 6);
        for (int v = 14; v >= 0; v--) hold(4'(v), 6);
        hold(4'hF, 6);
        hold(4'd3, 8);
        chk("pre_reset_wraps", 32'(wc1), 32'd2);
        chk("pre_reset_sticky", 32'(st1), 32'd1);
        do_reset(4'd3);
        hold(4'd3, 4);
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
